// File: rtl/frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_pkg
//  Description : Shared frame-memory definitions for the ingress/egress paths.
//                Holds the word info tags, the reader state encoding and
//                the default port-number type.
//  Revision    : 1.0  initial release
// ============================================================================
package frame_pkg;

    // Info tag carried with every frame-memory word
    localparam logic [1:0] INFO_MID    = 2'b00;
    localparam logic [1:0] INFO_SOF    = 2'b01;
    localparam logic [1:0] INFO_EOF    = 2'b10;
    localparam logic [1:0] INFO_SINGLE = 2'b11;

    localparam int PORT_WIDTH = 4;
    typedef logic [$clog2(PORT_WIDTH)-1:0] port_num_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Searches the request
//                vector starting at the pointer, wrapping, and returns the
//                first requesting index.
//  Ports       : i_req   - request vector (N)
//                i_ptr   - index searched first
//                o_grant - granted index (valid when o_any)
//                o_any   - at least one request present
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_grant,
    output logic             o_any
);

    // Rotate so that bit 0 of w_rot is the request at the pointer
    logic [N-1:0] w_rot;
    assign w_rot = N'({i_req, i_req} >> i_ptr);

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned       off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N) s = s - N;
        return s[IDX_W-1:0];
    endfunction

    // Descending scan: the lowest rotated offset is assigned last and wins
    always_comb begin
        o_grant = '0;
        o_any   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                o_grant = wrap_add(i_ptr, i);
                o_any   = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_egress_reader.sv
`default_nettype none
// ============================================================================
//  Module      : mem_egress_reader
//  Description : Read side of the shared frame memory. Round-robin picks an
//                egress port with a pending head frame that is ready, pops
//                its descriptor, streams the frame word by word until the
//                end tag (or the word limit) and presents each word on the
//                shared egress bus with a one-hot per-port valid.
//  Ports       : i_clk, i_reset          - clock, sync active-high reset
//                i_pend, i_port_ready    - per-port pending / ready
//                i_addr_port1..3         - head-frame start addresses
//                o_pop                   - one-hot descriptor-consumed pulse
//                o_rd_en, o_rd_addr      - memory read request
//                i_rd_data/info/extra    - memory response (pRD_LAT later)
//                o_data, o_info_port,
//                o_extra_byte            - egress word and sideband
//                o_valid_port            - one-hot word valid
//                o_port_num              - port being served
//                o_busy, o_err           - not-IDLE, forced-termination pulse
//  Revision    : 1.0  initial release
// ============================================================================
module mem_egress_reader
    import frame_pkg::*;
#(
    parameter int pPORT_WIDTH = 4,
    parameter int pNUM_PORTS  = 3,
    parameter int pADDR_W     = 10,
    parameter int pRD_LAT     = 1,
    parameter int pMAX_WORDS  = 512
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [pNUM_PORTS-1:0]          i_pend,
    input  logic [pADDR_W-1:0]             i_addr_port1,
    input  logic [pADDR_W-1:0]             i_addr_port2,
    input  logic [pADDR_W-1:0]             i_addr_port3,
    input  logic [pNUM_PORTS-1:0]          i_port_ready,
    output logic [pNUM_PORTS-1:0]          o_pop,
    output logic                           o_rd_en,
    output logic [pADDR_W-1:0]             o_rd_addr,
    input  logic [31:0]                    i_rd_data,
    input  logic [1:0]                     i_rd_info,
    input  logic [1:0]                     i_rd_extra,
    output logic [31:0]                    o_data,
    output logic [pNUM_PORTS-1:0]          o_valid_port,
    output logic [$clog2(pPORT_WIDTH)-1:0] o_port_num,
    output logic [1:0]                     o_info_port,
    output logic [1:0]                     o_extra_byte,
    output logic                           o_busy,
    output logic                           o_err
);

    localparam int PN_W  = $clog2(pPORT_WIDTH);
    localparam int IDX_W = (pNUM_PORTS > 1) ? $clog2(pNUM_PORTS) : 1;
    localparam int CNT_W = $clog2(pRD_LAT + 2);
    localparam int WC_W  = $clog2(pMAX_WORDS + 1);

    state_t                  r_state;
    logic [IDX_W-1:0]        r_ptr;
    logic [IDX_W-1:0]        r_sel;
    logic [pRD_LAT-1:0]      r_pipe;
    logic [CNT_W-1:0]        r_inflight;
    logic [WC_W-1:0]         r_words;
    logic [pNUM_PORTS-1:0]   r_pop;
    logic                    r_rd_en;
    logic [pADDR_W-1:0]      r_rd_addr;
    logic [31:0]             r_data;
    logic [pNUM_PORTS-1:0]   r_valid;
    logic [PN_W-1:0]         r_port_num;
    logic [1:0]              r_info;
    logic [1:0]              r_extra;
    logic                    r_err;

    logic [IDX_W-1:0]        w_grant;
    logic                    w_any;
    logic [pADDR_W-1:0]      w_start;
    logic                    w_ret;
    logic                    w_accept;
    logic                    w_force;
    logic                    w_end;
    logic [CNT_W-1:0]        w_cnt_next;

    rr_pick #(
        .N     (pNUM_PORTS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req   (i_pend & i_port_ready),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    always_comb begin
        case (w_grant)
            IDX_W'(0): w_start = i_addr_port1;
            IDX_W'(1): w_start = i_addr_port2;
            default:   w_start = i_addr_port3;
        endcase
    end

    // r_pipe tracks which cycles carry a memory response; the top bit marks
    // a word returning in the current cycle.
    generate
        if (pRD_LAT == 1) begin : g_pipe_1
            always_ff @(posedge i_clk) begin
                if (i_reset) r_pipe <= '0;
                else         r_pipe <= r_rd_en;
            end
        end else begin : g_pipe_n
            always_ff @(posedge i_clk) begin
                if (i_reset) r_pipe <= '0;
                else         r_pipe <= {r_pipe[pRD_LAT-2:0], r_rd_en};
            end
        end
    endgenerate

    assign w_ret      = r_pipe[pRD_LAT-1];
    // Responses are only accepted while reading; anything returning in
    // DRAIN belongs to reads issued past the last word.
    assign w_accept   = (r_state == READ) && w_ret;
    assign w_force    = (r_words == WC_W'(pMAX_WORDS - 1)) && !i_rd_info[1];
    assign w_end      = w_accept && (i_rd_info[1] || w_force);
    assign w_cnt_next = r_inflight + CNT_W'(r_rd_en) - CNT_W'(w_ret);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_sel      <= '0;
            r_inflight <= '0;
            r_words    <= '0;
            r_pop      <= '0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_data     <= '0;
            r_valid    <= '0;
            r_port_num <= '0;
            r_info     <= '0;
            r_extra    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_pop      <= '0;
            r_valid    <= '0;
            r_err      <= 1'b0;
            r_inflight <= w_cnt_next;

            if (w_accept) begin
                r_data  <= i_rd_data;
                r_info  <= w_force ? INFO_EOF : i_rd_info;
                r_extra <= i_rd_extra;
                r_valid <= pNUM_PORTS'(1) << r_sel;
                r_err   <= w_force;
                r_words <= r_words + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_sel      <= w_grant;
                        r_port_num <= PN_W'(w_grant);
                        r_rd_addr  <= w_start;
                        r_rd_en    <= 1'b1;
                        r_pop      <= pNUM_PORTS'(1) << w_grant;
                        r_words    <= '0;
                        r_ptr      <= (w_grant == IDX_W'(pNUM_PORTS - 1)) ? '0
                                                                          : w_grant + 1'b1;
                        r_state    <= READ;
                    end
                end
                READ: begin
                    if (w_end) begin
                        r_rd_en <= 1'b0;
                        r_state <= DRAIN;
                    end else begin
                        r_rd_addr <= r_rd_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_cnt_next == '0) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_pop        = r_pop;
    assign o_rd_en      = r_rd_en;
    assign o_rd_addr    = r_rd_addr;
    assign o_data       = r_data;
    assign o_valid_port = r_valid;
    assign o_port_num   = r_port_num;
    assign o_info_port  = r_info;
    assign o_extra_byte = r_extra;
    assign o_busy       = (r_state != IDLE);
    assign o_err        = r_err;

endmodule
`default_nettype wire
